// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions.
// - N_DEF / Q_DEF: default sample width and twiddle fractional bits.
// - cplx_t: complex sample at the default width.
// - rnd(q): round-half-up constant added before a right shift by q.
// - sat_n(v, n): clamp a signed value to the n-bit two's complement range.
package fft_pkg;

  localparam int unsigned N_DEF = 16;
  localparam int unsigned Q_DEF = 8;

  typedef struct packed {
    logic signed [N_DEF-1:0] re;
    logic signed [N_DEF-1:0] im;
  } cplx_t;

  function automatic logic [63:0] rnd(input int unsigned q);
    return 64'd1 << (q - 1);
  endfunction

  function automatic logic signed [63:0] sat_n(input logic signed [63:0] v,
                                               input int unsigned      n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cmul_round.sv
// Two-stage complex multiply with rounding: p = a * W (or a * conj(W)).
// Stage 1 registers the four real products and the inverse flag; stage 2 combines
// them and rounds half up by Q fractional bits. Both stages advance on en_i.
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   en_i                  pipeline advance
//   inverse_i             use conj(W)
//   a_re_i/a_im_i         multiplicand (N bits)
//   w_re_i/w_im_i         twiddle (N bits, Q fractional)
//   p_re_o/p_im_o         rounded product (PW bits, lossless)
module cmul_round
  import fft_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned Q  = Q_DEF,
  parameter int unsigned PW = 2 * N + 2 - Q
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 inverse_i,
  input  logic signed [N-1:0]  a_re_i,
  input  logic signed [N-1:0]  a_im_i,
  input  logic signed [N-1:0]  w_re_i,
  input  logic signed [N-1:0]  w_im_i,
  output logic signed [PW-1:0] p_re_o,
  output logic signed [PW-1:0] p_im_o
);

  localparam int unsigned MW = 2 * N;
  localparam int unsigned ZW = 2 * N + 2;
  localparam logic signed [ZW-1:0] Rnd = ZW'(rnd(Q));

  logic signed [MW-1:0] rr_q, ii_q, ri_q, ir_q;
  logic                 inv_q;
  logic signed [ZW-1:0] sum_re, sum_im;
  logic signed [PW-1:0] p_re_d, p_im_d, p_re_q, p_im_q;

  // Conjugation is applied as a sign choice on the combine, so W_im is never
  // negated and -2^(N-1) needs no extra bit.
  always_comb begin
    if (inv_q) begin
      sum_re = ZW'(rr_q) + ZW'(ii_q);
      sum_im = ZW'(ir_q) - ZW'(ri_q);
    end else begin
      sum_re = ZW'(rr_q) - ZW'(ii_q);
      sum_im = ZW'(ir_q) + ZW'(ri_q);
    end
    p_re_d = PW'((sum_re + Rnd) >>> Q);
    p_im_d = PW'((sum_im + Rnd) >>> Q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      ii_q   <= '0;
      ri_q   <= '0;
      ir_q   <= '0;
      inv_q  <= 1'b0;
      p_re_q <= '0;
      p_im_q <= '0;
    end else if (en_i) begin
      rr_q   <= MW'(a_re_i) * MW'(w_re_i);
      ii_q   <= MW'(a_im_i) * MW'(w_im_i);
      ri_q   <= MW'(a_re_i) * MW'(w_im_i);
      ir_q   <= MW'(a_im_i) * MW'(w_re_i);
      inv_q  <= inverse_i;
      p_re_q <= p_re_d;
      p_im_q <= p_im_d;
    end
  end

  assign p_re_o = p_re_q;
  assign p_im_o = p_im_q;

endmodule

// File: rtl/butterfly2_pipe.sv
// Pipelined radix-2 DIT butterfly: out0 = in0 + in1*W', out1 = in0 - in1*W'.
// Three stages (products, rounded P, add/sub+scale+narrow), global stall when the
// output is held. Sticky overflow flag; a set on an exiting result beats a clear.
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_valid / o_ready               input handshake
//   i_in0_*, i_in1_*, i_twiddle_*   operands (N bits)
//   i_inverse, i_scale              per-transaction modes
//   i_ovf_clr                       clear sticky overflow
//   o_valid / i_ready               output handshake
//   o_out0_*, o_out1_*              results (N bits)
//   o_ovf                           sticky overflow
module butterfly2_pipe
  import fft_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned Q   = Q_DEF,
  parameter bit          SAT = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic signed [N-1:0] i_in0_re,
  input  logic signed [N-1:0] i_in0_im,
  input  logic signed [N-1:0] i_in1_re,
  input  logic signed [N-1:0] i_in1_im,
  input  logic signed [N-1:0] i_twiddle_re,
  input  logic signed [N-1:0] i_twiddle_im,
  input  logic                i_inverse,
  input  logic                i_scale,
  input  logic                i_ovf_clr,
  output logic                o_valid,
  input  logic                i_ready,
  output logic signed [N-1:0] o_out0_re,
  output logic signed [N-1:0] o_out0_im,
  output logic signed [N-1:0] o_out1_re,
  output logic signed [N-1:0] o_out1_im,
  output logic                o_ovf
);

  localparam int unsigned PW = 2 * N + 2 - Q;
  // Sums are carried wide enough that neither add/sub nor the +1 of scaling loses bits.
  localparam int unsigned SW = PW + 2;

  logic                 advance;
  logic                 v1_q, v2_q, valid_q;
  logic                 scale1_q, scale2_q;
  logic signed [N-1:0]  in0_re1_q, in0_im1_q, in0_re2_q, in0_im2_q;
  logic signed [PW-1:0] p_re, p_im;
  logic signed [N-1:0]  out_q [4];
  logic                 ovf_q, ovf_d;

  logic signed [SW-1:0] sum_raw [4];
  logic signed [SW-1:0] sum_sc  [4];
  logic signed [63:0]   wide    [4];
  logic signed [63:0]   clamped [4];
  logic signed [N-1:0]  res     [4];
  logic [3:0]           lane_ovf;

  assign advance = !valid_q || i_ready;
  assign o_ready = advance;

  cmul_round #(
    .N  (N),
    .Q  (Q),
    .PW (PW)
  ) u_cmul (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .en_i      (advance),
    .inverse_i (i_inverse),
    .a_re_i    (i_in1_re),
    .a_im_i    (i_in1_im),
    .w_re_i    (i_twiddle_re),
    .w_im_i    (i_twiddle_im),
    .p_re_o    (p_re),
    .p_im_o    (p_im)
  );

  // S3: lanes are out0_re, out0_im, out1_re, out1_im.
  always_comb begin
    sum_raw[0] = SW'(in0_re2_q) + SW'(p_re);
    sum_raw[1] = SW'(in0_im2_q) + SW'(p_im);
    sum_raw[2] = SW'(in0_re2_q) - SW'(p_re);
    sum_raw[3] = SW'(in0_im2_q) - SW'(p_im);
    for (int i = 0; i < 4; i++) begin
      sum_sc[i]   = scale2_q ? ((sum_raw[i] + SW'(1)) >>> 1) : sum_raw[i];
      wide[i]     = 64'(sum_sc[i]);
      clamped[i]  = sat_n(wide[i], N);
      lane_ovf[i] = (clamped[i] != wide[i]);
      res[i]      = SAT ? N'(clamped[i]) : N'(sum_sc[i]);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (i_ovf_clr) ovf_d = 1'b0;
    if (advance && v2_q && (|lane_ovf)) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      valid_q   <= 1'b0;
      scale1_q  <= 1'b0;
      scale2_q  <= 1'b0;
      in0_re1_q <= '0;
      in0_im1_q <= '0;
      in0_re2_q <= '0;
      in0_im2_q <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else begin
      ovf_q <= ovf_d;
      if (advance) begin
        v1_q      <= i_valid;
        scale1_q  <= i_scale;
        in0_re1_q <= i_in0_re;
        in0_im1_q <= i_in0_im;
        v2_q      <= v1_q;
        scale2_q  <= scale1_q;
        in0_re2_q <= in0_re1_q;
        in0_im2_q <= in0_im1_q;
        valid_q   <= v2_q;
        for (int i = 0; i < 4; i++) out_q[i] <= res[i];
      end
    end
  end

  assign o_valid   = valid_q;
  assign o_out0_re = out_q[0];
  assign o_out0_im = out_q[1];
  assign o_out1_re = out_q[2];
  assign o_out1_im = out_q[3];
  assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_butterfly2_pipe.sv
// Scoreboard bench for butterfly2_pipe: accepted inputs push a model result, the
// output monitor pops and compares whenever a result is consumed.
module tb_butterfly2_pipe;
  import fft_pkg::*;

  localparam int unsigned N = 16;
  localparam int unsigned Q = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0, o_ready, i_inverse = 1'b0, i_scale = 1'b0, i_ovf_clr = 1'b0;
  logic o_valid, i_ready = 1'b1, o_ovf;
  logic signed [N-1:0] i_in0_re = '0, i_in0_im = '0, i_in1_re = '0, i_in1_im = '0;
  logic signed [N-1:0] i_twiddle_re = '0, i_twiddle_im = '0;
  logic signed [N-1:0] o_out0_re, o_out0_im, o_out1_re, o_out1_im;

  butterfly2_pipe #(
    .N   (N),
    .Q   (Q),
    .SAT (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_in0_re     (i_in0_re),
    .i_in0_im     (i_in0_im),
    .i_in1_re     (i_in1_re),
    .i_in1_im     (i_in1_im),
    .i_twiddle_re (i_twiddle_re),
    .i_twiddle_im (i_twiddle_im),
    .i_inverse    (i_inverse),
    .i_scale      (i_scale),
    .i_ovf_clr    (i_ovf_clr),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_out0_re    (o_out0_re),
    .o_out0_im    (o_out0_im),
    .o_out1_re    (o_out1_re),
    .o_out1_im    (o_out1_im),
    .o_ovf        (o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    cplx_t o0;
    cplx_t o1;
    int    acc_cyc;
    bit    chk_lat;
  } exp_t;

  exp_t  sb[$];
  exp_t  e;
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    chk_lat_next = 1'b0;
  bit    fix_en = 1'b0;
  cplx_t fix0, fix1;
  bit    send_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: complex arithmetic straight from the definition, then clamp.
  function automatic exp_t model(input longint a0r, input longint a0i, input longint a1r,
                                 input longint a1i, input longint wr, input longint wi,
                                 input bit inv, input bit sc);
    exp_t   r;
    longint wc, pr, pi, half;
    longint s[4];
    half = longint'(1) <<< (Q - 1);
    wc   = inv ? -wi : wi;
    pr   = a1r * wr - a1i * wc;
    pi   = a1r * wc + a1i * wr;
    pr   = (pr + half) >>> Q;
    pi   = (pi + half) >>> Q;
    s[0] = a0r + pr;
    s[1] = a0i + pi;
    s[2] = a0r - pr;
    s[3] = a0i - pi;
    for (int k = 0; k < 4; k++) begin
      if (sc) s[k] = (s[k] + 1) >>> 1;
      if (s[k] > 32767) s[k] = 32767;
      if (s[k] < -32768) s[k] = -32768;
    end
    r.o0.re   = N'(s[0]);
    r.o0.im   = N'(s[1]);
    r.o1.re   = N'(s[2]);
    r.o1.im   = N'(s[3]);
    r.acc_cyc = 0;
    r.chk_lat = 1'b0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out0_re", o_out0_re, e.o0.re);
          check("out0_im", o_out0_im, e.o0.im);
          check("out1_re", o_out1_re, e.o1.re);
          check("out1_im", o_out1_im, e.o1.im);
          if (e.chk_lat) check("latency", cyc - e.acc_cyc, 3);
        end
      end
      if (i_valid && o_ready) begin
        e = model(i_in0_re, i_in0_im, i_in1_re, i_in1_im, i_twiddle_re, i_twiddle_im,
                  i_inverse, i_scale);
        if (fix_en) begin
          e.o0 = fix0;
          e.o1 = fix1;
        end
        e.acc_cyc = cyc;
        e.chk_lat = chk_lat_next;
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a0r, input int a0i, input int a1r, input int a1i,
                      input int wr, input int wi, input bit inv, input bit sc);
    bit acc;
    int n;
    i_in0_re     = N'(a0r);
    i_in0_im     = N'(a0i);
    i_in1_re     = N'(a1r);
    i_in1_im     = N'(a1i);
    i_twiddle_re = N'(wr);
    i_twiddle_im = N'(wi);
    i_inverse    = inv;
    i_scale      = sc;
    i_valid      = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = o_ready;
      step();
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  task automatic send_fixed(input int a0r, input int a0i, input int a1r, input int a1i,
                            input int wr, input int wi, input bit inv, input bit sc,
                            input int e0r, input int e0i, input int e1r, input int e1i);
    fix0.re = N'(e0r);
    fix0.im = N'(e0i);
    fix1.re = N'(e1r);
    fix1.im = N'(e1i);
    fix_en  = 1'b1;
    chk_lat_next = 1'b1;
    send(a0r, a0i, a1r, a1i, wr, wi, inv, sc);
    fix_en  = 1'b0;
    chk_lat_next = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check("drain_pending", sb.size(), 0);
    step();
  endtask

  task automatic send_rand(input bit inv, input bit sc);
    int w_lim;
    w_lim = ($urandom_range(0, 1) == 0) ? 256 : 32768;
    send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
         int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
         int'($urandom_range(0, 2 * w_lim - 1)) - w_lim,
         int'($urandom_range(0, 2 * w_lim - 1)) - w_lim, inv, sc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_valid", o_valid, 0);
    check("rst_ovf", o_ovf, 0);
    check("rst_out0_re", o_out0_re, 0);
    rst_n = 1'b1;
    check("rst_ready", o_ready, 1);
    step();

    // Directed vectors from the test plan
    send_fixed(362, -201, 362, 201, 220, -166, 1'b0, 1'b0, 803, -263, -79, -139);
    wait_drain();
    check("fwd_ovf", o_ovf, 0);
    send_fixed(362, -201, 362, 201, 220, -166, 1'b1, 1'b0, 543, 206, 181, -608);
    wait_drain();
    send_fixed(362, -201, 362, 201, 220, -166, 1'b0, 1'b1, 402, -131, -39, -69);
    wait_drain();
    check("scale_ovf", o_ovf, 0);

    // Saturation and sticky flag
    send_fixed(32767, 0, 32767, 0, 256, 0, 1'b0, 1'b0, 32767, 0, 0, 0);
    wait_drain();
    check("sat_ovf", o_ovf, 1);
    step();
    step();
    check("sat_ovf_sticky", o_ovf, 1);
    i_ovf_clr = 1'b1;
    check("ovf_before_clr_edge", o_ovf, 1);
    step();
    i_ovf_clr = 1'b0;
    check("ovf_cleared", o_ovf, 0);

    // Clear coinciding with a new overflow leaving S3: set wins
    send_fixed(32767, 0, 32767, 0, 256, 0, 1'b0, 1'b0, 32767, 0, 0, 0);
    step();
    i_ovf_clr = 1'b1;
    step();
    i_ovf_clr = 1'b0;
    check("set_wins_valid", o_valid, 1);
    check("set_wins_ovf", o_ovf, 1);
    wait_drain();

    // Back-pressure: 6 back-to-back, 3-cycle output stall mid-stream
    send_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 6; t++) send_rand(t[0], t[1]);
        send_done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!o_valid && n < 20) begin
          step();
          n++;
        end
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_ready", o_ready, 0);
          check("stall_valid", o_valid, 1);
          step();
        end
        i_ready = 1'b1;
      end
    join
    wait_drain();

    // Randomized stream with random gaps and random downstream readiness
    send_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 40; t++) begin
          if ($urandom_range(0, 3) == 0) step();
          send_rand($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        send_done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!send_done && n < 2000) begin
          i_ready = ($urandom_range(0, 3) != 0);
          step();
          n++;
        end
        i_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with two transactions in flight
    send_fixed(32767, 0, 32767, 0, 256, 0, 1'b0, 1'b0, 32767, 0, 0, 0);
    wait_drain();
    check("pre_rst_ovf", o_ovf, 1);
    i_in0_re = 16'sd1000;
    i_in1_re = 16'sd500;
    i_twiddle_re = 16'sd256;
    i_valid = 1'b1;
    step();
    step();
    i_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_ovf", o_ovf, 0);
    check("midrst_out1_re", o_out1_re, 0);
    step();
    step();
    rst_n = 1'b1;
    check("post_rst_ready", o_ready, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("no_stale_output", o_valid, 0);
    end
    send_fixed(362, -201, 362, 201, 220, -166, 1'b0, 1'b0, 803, -263, -79, -139);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
